// File: rtl/time_bcd_counter.sv
// Time-of-day counter in BCD digit fields (24-hour), advanced by a clk prescaler
// at 1 Hz and stepped by single-cycle minute/hour set pulses.
module time_bcd_counter #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       set_min_inc,
  input  logic       set_hr_inc,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic [3:0] hr_ones,
  output logic [1:0] hr_tens,
  output logic       sec_tick,
  output logic       day_rollover
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc;

  logic sec_max, min_max, hr_max;
  logic [3:0] sec_ones_nx, min_ones_nx, hr_ones_nx;
  logic [2:0] sec_tens_nx, min_tens_nx;
  logic [1:0] hr_tens_nx;

  assign sec_max = (sec_ones == 4'd9) && (sec_tens == 3'd5);
  assign min_max = (min_ones == 4'd9) && (min_tens == 3'd5);
  assign hr_max  = (hr_ones  == 4'd3) && (hr_tens  == 2'd2);

  // Each field's value after a +1 step with its own wrap; carries between
  // fields are decided in the sequential block.
  always_comb begin
    sec_ones_nx = (sec_ones == 4'd9) ? 4'd0 : sec_ones + 4'd1;
    sec_tens_nx = sec_tens;
    if (sec_ones == 4'd9) sec_tens_nx = (sec_tens == 3'd5) ? 3'd0 : sec_tens + 3'd1;

    min_ones_nx = (min_ones == 4'd9) ? 4'd0 : min_ones + 4'd1;
    min_tens_nx = min_tens;
    if (min_ones == 4'd9) min_tens_nx = (min_tens == 3'd5) ? 3'd0 : min_tens + 3'd1;

    hr_ones_nx = hr_ones + 4'd1;
    hr_tens_nx = hr_tens;
    if (hr_max) begin
      hr_ones_nx = 4'd0;
      hr_tens_nx = 2'd0;
    end else if (hr_ones == 4'd9) begin
      hr_ones_nx = 4'd0;
      hr_tens_nx = hr_tens + 2'd1;
    end
  end

  // NOTE: state uses non-blocking assignments so every field updates from the
  // same pre-edge values, which is what lets the BCD ripple happen in one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc        <= '0;
      sec_ones     <= '0;
      sec_tens     <= '0;
      min_ones     <= '0;
      min_tens     <= '0;
      hr_ones      <= '0;
      hr_tens      <= '0;
      sec_tick     <= 1'b0;
      day_rollover <= 1'b0;
    end else begin
      sec_tick     <= 1'b0;
      day_rollover <= 1'b0;
      if (set_min_inc || set_hr_inc) begin
        // Setting the clock restarts the current second from zero.
        presc    <= '0;
        sec_ones <= '0;
        sec_tens <= '0;
        if (set_min_inc) begin
          min_ones <= min_ones_nx;
          min_tens <= min_tens_nx;
        end
        if (set_hr_inc) begin
          hr_ones <= hr_ones_nx;
          hr_tens <= hr_tens_nx;
        end
      end else if (run) begin
        if (presc == TERM) begin
          presc    <= '0;
          sec_tick <= 1'b1;
          sec_ones <= sec_ones_nx;
          sec_tens <= sec_tens_nx;
          if (sec_max) begin
            min_ones <= min_ones_nx;
            min_tens <= min_tens_nx;
          end
          if (sec_max && min_max) begin
            hr_ones <= hr_ones_nx;
            hr_tens <= hr_tens_nx;
          end
          day_rollover <= sec_max && min_max && hr_max;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_time_bcd_counter.sv
// Bench for time_bcd_counter: seconds-of-day reference model compared every
// cycle, directed scenarios with literal expectations, then random stimulus.
module tb_time_bcd_counter;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       set_min_inc = 1'b0;
  logic       set_hr_inc = 1'b0;
  logic [3:0] sec_ones, min_ones, hr_ones;
  logic [2:0] sec_tens, min_tens;
  logic [1:0] hr_tens;
  logic       sec_tick, day_rollover;

  time_bcd_counter #(.TICKS_PER_SEC(T)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .set_min_inc(set_min_inc), .set_hr_inc(set_hr_inc),
    .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens),
    .hr_ones(hr_ones), .hr_tens(hr_tens),
    .sec_tick(sec_tick), .day_rollover(day_rollover)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] bcd(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  logic [19:0] dut_time;
  assign dut_time = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};

  // Reference model: time as seconds since midnight, prescaler as a plain count.
  int tod = 0;
  int pc = 0;
  int mh, mm;
  bit mtick = 1'b0, mroll = 1'b0, mvalid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      tod = 0; pc = 0; mtick = 1'b0; mroll = 1'b0; mvalid = 1'b1;
    end else if (mvalid) begin
      mtick = 1'b0;
      mroll = 1'b0;
      if (set_min_inc || set_hr_inc) begin
        mh = tod / 3600;
        mm = (tod / 60) % 60;
        if (set_min_inc) mm = (mm + 1) % 60;
        if (set_hr_inc)  mh = (mh + 1) % 24;
        tod = mh * 3600 + mm * 60;
        pc = 0;
      end else if (run) begin
        if (pc == T - 1) begin
          pc = 0;
          tod = (tod + 1) % 86400;
          mtick = 1'b1;
          mroll = (tod == 0);
        end else begin
          pc++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("cmp_time", 32'(dut_time), 32'(bcd(tod / 3600, (tod / 60) % 60, tod % 60)));
      check("cmp_tick", 32'(sec_tick), 32'(mtick));
      check("cmp_roll", 32'(day_rollover), 32'(mroll));
    end
  end

  task automatic cyc(input logic rn, input logic r, input logic mi, input logic hi);
    @(negedge clk);
    rst_n = rn; run = r; set_min_inc = mi; set_hr_inc = hi;
    @(posedge clk);
    #1;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic hr_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic min_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_time", 32'(dut_time), 32'(bcd(0, 0, 0)));
    check("rst_tick", 32'(sec_tick), 32'd0);
    check("rst_roll", 32'(day_rollover), 32'd0);

    // 1: first second after reset
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      check("t1_tick", 32'(sec_tick), (i == 3) ? 32'd1 : 32'd0);
    end
    check("t1_time", 32'(dut_time), 32'(bcd(0, 0, 1)));
    check("t1_model", 32'(tod), 32'd1);

    // 2: day rollover
    hr_n(23);
    min_n(59);
    check("t2_set", 32'(dut_time), 32'(bcd(23, 59, 0)));
    run_n(59 * T);
    check("t2_pre", 32'(dut_time), 32'(bcd(23, 59, 59)));
    check("t2_pre_roll", 32'(day_rollover), 32'd0);
    run_n(T);
    check("t2_time", 32'(dut_time), 32'(bcd(0, 0, 0)));
    check("t2_tick", 32'(sec_tick), 32'd1);
    check("t2_roll", 32'(day_rollover), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("t2_roll_gone", 32'(day_rollover), 32'd0);

    // 3: minute set at 59 does not carry into hours
    hr_n(12);
    min_n(59);
    run_n(30 * T);
    check("t3_pre", 32'(dut_time), 32'(bcd(12, 59, 30)));
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check("t3_time", 32'(dut_time), 32'(bcd(12, 0, 0)));
    check("t3_tick", 32'(sec_tick), 32'd0);

    // 4: hour set wraps 23 -> 00 without rollover; both pulses together
    min_n(5);
    hr_n(11);
    check("t4_pre", 32'(dut_time), 32'(bcd(23, 5, 0)));
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("t4_time", 32'(dut_time), 32'(bcd(0, 5, 0)));
    check("t4_roll", 32'(day_rollover), 32'd0);
    hr_n(9);
    min_n(4);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    check("t4_both", 32'(dut_time), 32'(bcd(10, 10, 0)));
    check("t4_model", 32'(tod), 32'(10 * 3600 + 10 * 60));

    // 5: set pulse on a terminal prescaler edge wins
    run_n(T - 1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check("t5_time", 32'(dut_time), 32'(bcd(10, 11, 0)));
    check("t5_tick", 32'(sec_tick), 32'd0);
    for (int i = 0; i < T; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      check("t5_next_tick", 32'(sec_tick), (i == T - 1) ? 32'd1 : 32'd0);
    end
    check("t5_next_time", 32'(dut_time), 32'(bcd(10, 11, 1)));

    // 6: run=0 freezes time and prescaler; reset mid-count drops the partial second
    run_n(2);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      check("t6_frozen", 32'(dut_time), 32'(bcd(10, 11, 1)));
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("t6_resume_a", 32'(sec_tick), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("t6_resume_b", 32'(sec_tick), 32'd1);
    check("t6_resume_time", 32'(dut_time), 32'(bcd(10, 11, 2)));
    run_n(2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("t6_rst_time", 32'(dut_time), 32'(bcd(0, 0, 0)));
    for (int i = 0; i < T; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      check("t6_rst_tick", 32'(sec_tick), (i == T - 1) ? 32'd1 : 32'd0);
    end
    check("t6_rst_next", 32'(dut_time), 32'(bcd(0, 0, 1)));

    // Random stimulus checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 31) == 0),
          ($urandom_range(0, 31) == 0));
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
